// File: rtl/router_pkg.sv
// Shared router definitions: header field widths, header field extractors and
// the state encodings used by the per-destination packet FIFO.
package router_pkg;

    localparam int DATA_SIZE       = 8;
    localparam int PKT_LENGTH_BITS = 5;
    localparam int PKT_ADDR_BITS   = 3;

    typedef enum logic [1:0] {
        W_HDR  = 2'd0,
        W_PLD  = 2'd1,
        W_DROP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_HDR = 1'b0,
        R_PLD = 1'b1
    } rd_state_e;

    function automatic logic [PKT_LENGTH_BITS-1:0] hdr_len(input logic [DATA_SIZE-1:0] hdr);
        return hdr[PKT_LENGTH_BITS-1:0];
    endfunction

    function automatic logic [PKT_ADDR_BITS-1:0] hdr_addr(input logic [DATA_SIZE-1:0] hdr);
        return hdr[DATA_SIZE-1 -: PKT_ADDR_BITS];
    endfunction

endpackage

// File: rtl/chn_pkt_fifo_mem.sv
// Packet byte storage: one write port, one registered read port.
// Storage is not reset; only the read register is.
module chn_pkt_fifo_mem #(
    parameter int data_size = 8,
    parameter int addr_bits = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_we,
    input  logic [addr_bits-1:0] i_waddr,
    input  logic [data_size-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [addr_bits-1:0] i_raddr,
    output logic [data_size-1:0] o_rdata
);

    logic [data_size-1:0] mem_r [2**addr_bits];

    // Byte write into storage.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_waddr] <= i_wdata;
        end
    end

    // Registered read; holds its value when no read is issued.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rdata <= {data_size{1'b0}};
        end else if (i_re) begin
            o_rdata <= mem_r[i_raddr];
        end
    end

endmodule

// File: rtl/chn_pkt_fifo.sv
// Per-destination packet FIFO: buffers header+payload bytes, exposes only
// committed packets to the reader and discards any packet that overflows.
module chn_pkt_fifo
    import router_pkg::*;
#(
    parameter int data_size       = DATA_SIZE,
    parameter int pkt_length_bits = PKT_LENGTH_BITS,
    parameter int depth_log2      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr_en,
    input  logic [data_size-1:0]  i_data_in,
    input  logic                  i_rd_en,
    input  logic                  i_clr_errors,
    output logic [data_size-1:0]  o_data_out,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [depth_log2:0]   o_pkt_cnt,
    output logic                  o_pkt_avail,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int ptr_w = depth_log2 + 1;
    localparam logic [ptr_w-1:0]           ptr_zero = {ptr_w{1'b0}};
    localparam logic [ptr_w-1:0]           ptr_one  = {{(ptr_w-1){1'b0}}, 1'b1};
    localparam logic [pkt_length_bits-1:0] len_zero = {pkt_length_bits{1'b0}};
    localparam logic [pkt_length_bits-1:0] len_one  = {{(pkt_length_bits-1){1'b0}}, 1'b1};

    wr_state_e                wr_state_r, wr_state_s;
    logic [ptr_w-1:0]         wr_ptr_r, wr_ptr_s;
    logic [ptr_w-1:0]         cmt_ptr_r, cmt_ptr_s;
    logic [pkt_length_bits-1:0] len_cnt_r, len_cnt_s;
    logic                     mem_we_s, commit_s, ovf_set_s;

    rd_state_e                rd_state_r, rd_state_s;
    logic [ptr_w-1:0]         rd_ptr_r, rd_ptr_s;
    logic [pkt_length_bits-1:0] rd_len_r, rd_len_s, rem_s;
    logic                     hdr_vld_r, hdr_vld_s;
    logic                     rd_fire_s, pkt_dec_s, unf_set_s;

    logic [ptr_w-1:0]         pkt_cnt_r;
    logic                     overflow_r, underflow_r;
    logic                     full_s, empty_s;
    logic [data_size-1:0]     rd_data_s;

    assign full_s  = (wr_ptr_r[ptr_w-1] != rd_ptr_r[ptr_w-1]) &&
                     (wr_ptr_r[ptr_w-2:0] == rd_ptr_r[ptr_w-2:0]);
    assign empty_s = (rd_ptr_r == cmt_ptr_r);

    assign o_full      = full_s;
    assign o_empty     = empty_s;
    assign o_pkt_cnt   = pkt_cnt_r;
    assign o_pkt_avail = (pkt_cnt_r != ptr_zero);
    assign o_overflow  = overflow_r;
    assign o_underflow = underflow_r;
    assign o_data_out  = rd_data_s;

    chn_pkt_fifo_mem #(
        .data_size (data_size),
        .addr_bits (depth_log2)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_we    (mem_we_s),
        .i_waddr (wr_ptr_r[ptr_w-2:0]),
        .i_wdata (i_data_in),
        .i_re    (rd_fire_s),
        .i_raddr (rd_ptr_r[ptr_w-2:0]),
        .o_rdata (rd_data_s)
    );

    // Write FSM next state: store, commit on the last byte, roll back on overflow.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_ptr_s   = wr_ptr_r;
        cmt_ptr_s  = cmt_ptr_r;
        len_cnt_s  = len_cnt_r;
        mem_we_s   = 1'b0;
        commit_s   = 1'b0;
        ovf_set_s  = 1'b0;
        case (wr_state_r)
            W_HDR: begin
                if (i_wr_en) begin
                    len_cnt_s = hdr_len(i_data_in);
                    if (full_s) begin
                        ovf_set_s  = 1'b1;
                        wr_ptr_s   = cmt_ptr_r;
                        wr_state_s = (hdr_len(i_data_in) == len_zero) ? W_HDR : W_DROP;
                    end else begin
                        mem_we_s = 1'b1;
                        wr_ptr_s = wr_ptr_r + ptr_one;
                        if (hdr_len(i_data_in) == len_zero) begin
                            commit_s  = 1'b1;
                            cmt_ptr_s = wr_ptr_r + ptr_one;
                        end else begin
                            wr_state_s = W_PLD;
                        end
                    end
                end else begin
                    wr_state_s = W_HDR;
                end
            end
            W_PLD: begin
                if (i_wr_en) begin
                    len_cnt_s = len_cnt_r - len_one;
                    if (full_s) begin
                        ovf_set_s  = 1'b1;
                        wr_ptr_s   = cmt_ptr_r;
                        wr_state_s = (len_cnt_r == len_one) ? W_HDR : W_DROP;
                    end else begin
                        mem_we_s = 1'b1;
                        wr_ptr_s = wr_ptr_r + ptr_one;
                        if (len_cnt_r == len_one) begin
                            commit_s   = 1'b1;
                            cmt_ptr_s  = wr_ptr_r + ptr_one;
                            wr_state_s = W_HDR;
                        end else begin
                            wr_state_s = W_PLD;
                        end
                    end
                end else begin
                    wr_state_s = W_PLD;
                end
            end
            W_DROP: begin
                if (i_wr_en) begin
                    len_cnt_s  = len_cnt_r - len_one;
                    wr_state_s = (len_cnt_r == len_one) ? W_HDR : W_DROP;
                end else begin
                    wr_state_s = W_DROP;
                end
            end
            default: begin
                wr_state_s = W_HDR;
            end
        endcase
    end

    // Write-side state and pointers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_state_r <= W_HDR;
            wr_ptr_r   <= ptr_zero;
            cmt_ptr_r  <= ptr_zero;
            len_cnt_r  <= len_zero;
        end else begin
            wr_state_r <= wr_state_s;
            wr_ptr_r   <= wr_ptr_s;
            cmt_ptr_r  <= cmt_ptr_s;
            len_cnt_r  <= len_cnt_s;
        end
    end

    // Read FSM next state. The header byte is only visible on the registered
    // read data one cycle after it is read, so its length is picked up then.
    always_comb begin
        rd_fire_s  = i_rd_en & ~empty_s;
        unf_set_s  = i_rd_en & empty_s;
        rd_ptr_s   = rd_fire_s ? (rd_ptr_r + ptr_one) : rd_ptr_r;
        rem_s      = hdr_vld_r ? hdr_len(rd_data_s) : rd_len_r;
        rd_state_s = rd_state_r;
        rd_len_s   = rd_len_r;
        hdr_vld_s  = 1'b0;
        pkt_dec_s  = 1'b0;
        case (rd_state_r)
            R_HDR: begin
                if (rd_fire_s) begin
                    hdr_vld_s  = 1'b1;
                    rd_state_s = R_PLD;
                end else begin
                    rd_state_s = R_HDR;
                end
            end
            R_PLD: begin
                if (rem_s == len_zero) begin
                    // Zero-length packet just finished; any byte read now is a header.
                    pkt_dec_s = 1'b1;
                    if (rd_fire_s) begin
                        hdr_vld_s  = 1'b1;
                        rd_state_s = R_PLD;
                    end else begin
                        rd_state_s = R_HDR;
                    end
                end else if (rd_fire_s) begin
                    if (rem_s == len_one) begin
                        pkt_dec_s  = 1'b1;
                        rd_state_s = R_HDR;
                    end else begin
                        rd_len_s = rem_s - len_one;
                    end
                end else begin
                    rd_len_s = rem_s;
                end
            end
            default: begin
                rd_state_s = R_HDR;
            end
        endcase
    end

    // Read-side state and pointer.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_state_r <= R_HDR;
            rd_ptr_r   <= ptr_zero;
            rd_len_r   <= len_zero;
            hdr_vld_r  <= 1'b0;
        end else begin
            rd_state_r <= rd_state_s;
            rd_ptr_r   <= rd_ptr_s;
            rd_len_r   <= rd_len_s;
            hdr_vld_r  <= hdr_vld_s;
        end
    end

    // Committed packet count; simultaneous commit and completion cancel out.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pkt_cnt_r <= ptr_zero;
        end else begin
            case ({commit_s, pkt_dec_s})
                2'b10:   pkt_cnt_r <= pkt_cnt_r + ptr_one;
                2'b01:   pkt_cnt_r <= pkt_cnt_r - ptr_one;
                default: pkt_cnt_r <= pkt_cnt_r;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set_s | (overflow_r & ~i_clr_errors);
            underflow_r <= unf_set_s | (underflow_r & ~i_clr_errors);
        end
    end

endmodule
